// File: rtl/cave_ddr_pkg.sv
// cave_ddr_pkg: shared FSM state and DDR field widths for the DDR arbiter.
package cave_ddr_pkg;
  localparam int DDR_DATA_W = 64;
  localparam int DDR_BE_W = 8;
  localparam int DDR_BURST_W = 8;
  typedef enum logic [1:0] {IDLE, CMD, RDATA, WDATA} state_t;
endpackage

// File: rtl/ddr_arb_pick.sv
// ddr_arb_pick: picks the pending requester closest at or after ptr, as one-hot and index.
module ddr_arb_pick #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         idx
);
  int best, d;
  always_comb begin
    idx = '0;
    best = NUM_REQ;
    d = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i + NUM_REQ - int'(ptr)) % NUM_REQ;
      if (req[i] && d < best) begin
        best = d;
        idx = 2'(i);
      end
    end
  end
  assign gnt = |req ? NUM_REQ'(1) << idx : '0;
endmodule

// File: rtl/ddr_arbiter.sv
// ddr_arbiter: multi-requester DDR command arbiter, fixed priority or round-robin
// when DDR_ARB_ROUND_ROBIN_EN is defined.
module ddr_arbiter
  import cave_ddr_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W = 29
) (
  input  logic                          clk_sys,
  input  logic                          rst_sys_n,
  input  logic [NUM_REQ-1:0]            req_rd,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DDR_BURST_W-1:0] req_burst,
  input  logic [NUM_REQ*DDR_DATA_W-1:0] req_din,
  input  logic [NUM_REQ*DDR_BE_W-1:0]   req_be,
  output logic [NUM_REQ-1:0]            req_wait_n,
  output logic [NUM_REQ-1:0]            req_valid,
  output logic [DDR_DATA_W-1:0]         req_dout,
  output logic                          ddr_rd,
  output logic                          ddr_wr,
  output logic [ADDR_W-1:0]             ddr_addr,
  output logic [DDR_BURST_W-1:0]        ddr_burst,
  output logic [DDR_DATA_W-1:0]         ddr_din,
  output logic [DDR_BE_W-1:0]           ddr_be,
  input  logic                          ddr_busy,
  input  logic [DDR_DATA_W-1:0]         ddr_dout,
  input  logic                          ddr_valid,
  output logic [1:0]                    owner
);
  state_t state;
  logic [DDR_BURST_W-1:0] cnt, win_burst;
  logic rd_op, act, acc, last, grant;
  logic [NUM_REQ-1:0] gnt, one;
  logic [1:0] idx, ptr;
  ddr_arb_pick #(.NUM_REQ(NUM_REQ)) pick (.req(req_rd | req_wr), .ptr, .gnt, .idx);
  assign one = NUM_REQ'(1) << owner;
  assign act = state == CMD || state == WDATA;
  assign ddr_rd = state == CMD && rd_op && req_rd[owner];
  assign ddr_wr = act && !rd_op && req_wr[owner];
  assign ddr_addr = act ? req_addr[owner*ADDR_W +: ADDR_W] : '0;
  assign ddr_burst = act ? req_burst[owner*DDR_BURST_W +: DDR_BURST_W] : '0;
  assign ddr_din = act ? req_din[owner*DDR_DATA_W +: DDR_DATA_W] : '0;
  assign ddr_be = act ? req_be[owner*DDR_BE_W +: DDR_BE_W] : '0;
  assign req_wait_n = act && !ddr_busy ? one : '0;
  assign req_valid = state == RDATA && ddr_valid ? one : '0;
  assign req_dout = state == RDATA ? ddr_dout : '0;
  assign acc = (ddr_rd || ddr_wr) && !ddr_busy;
  assign last = cnt == DDR_BURST_W'(1);
  assign grant = |gnt;
  assign win_burst = req_burst[idx*DDR_BURST_W +: DDR_BURST_W];
`ifdef DDR_ARB_ROUND_ROBIN_EN
  // ptr holds the requester just after the last owner, where the next search starts
  always_ff @(posedge clk_sys)
    if (!rst_sys_n) ptr <= '0;
    else if (state == IDLE && grant) ptr <= idx == 2'(NUM_REQ-1) ? 2'd0 : idx + 2'd1;
`else
  assign ptr = 2'd0;
`endif
  always_ff @(posedge clk_sys) begin
    if (!rst_sys_n) begin
      state <= IDLE;
      owner <= '0;
      cnt <= '0;
      rd_op <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          owner <= idx;
          cnt <= win_burst == '0 ? DDR_BURST_W'(1) : win_burst;
          rd_op <= req_rd[idx];
          state <= CMD;
        end
        CMD, WDATA: if (acc) begin
          if (rd_op) state <= RDATA;
          else begin
            cnt <= cnt - 1'b1;
            state <= last ? IDLE : WDATA;
          end
        end
        RDATA: if (ddr_valid) begin
          cnt <= cnt - 1'b1;
          state <= last ? IDLE : RDATA;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr_arbiter.sv
// tb_ddr_arbiter: transaction-level reference model compared every cycle, plus directed scenarios.
module tb_ddr_arbiter;
  localparam int N = 3;
  localparam int AW = 29;
  logic clk_sys = 1'b0;
  logic rst_sys_n = 1'b0;
  logic [N-1:0] req_rd = '0, req_wr = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*8-1:0] req_burst = '0;
  logic [N*64-1:0] req_din = '0;
  logic [N*8-1:0] req_be = '0;
  logic ddr_busy = 1'b0, ddr_valid = 1'b0;
  logic [63:0] ddr_dout = '0;
  logic [N-1:0] req_wait_n, req_valid;
  logic [63:0] req_dout, ddr_din;
  logic ddr_rd, ddr_wr;
  logic [AW-1:0] ddr_addr;
  logic [7:0] ddr_burst, ddr_be;
  logic [1:0] owner;

  always #5 clk_sys = ~clk_sys;

  ddr_arbiter #(.NUM_REQ(N), .ADDR_W(AW)) dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .req_rd(req_rd), .req_wr(req_wr),
    .req_addr(req_addr), .req_burst(req_burst), .req_din(req_din), .req_be(req_be),
    .req_wait_n(req_wait_n), .req_valid(req_valid), .req_dout(req_dout),
    .ddr_rd(ddr_rd), .ddr_wr(ddr_wr), .ddr_addr(ddr_addr), .ddr_burst(ddr_burst),
    .ddr_din(ddr_din), .ddr_be(ddr_be), .ddr_busy(ddr_busy), .ddr_dout(ddr_dout),
    .ddr_valid(ddr_valid), .owner(owner)
  );

  int compared = 0, mismatched = 0;
  int m_own = -1, m_last = 0, m_next = 0, m_left = 0, w, c;
  bit m_rd = 0, m_started = 0, cmd_ph;
  int grants[$];
  int n_rdacc = 0, n_wracc = 0, n_wait0 = 0, n_b0 = 0;
  int n_val[N];
  logic [N-1:0] e_wait, e_val;
  logic e_rd, e_wr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_sys) begin
    e_wait = '0;
    e_val = '0;
    e_rd = 1'b0;
    e_wr = 1'b0;
    cmd_ph = m_own >= 0 && !(m_rd && m_started);
    if (cmd_ph) begin
      e_rd = m_rd && req_rd[m_own];
      e_wr = !m_rd && req_wr[m_own];
      e_wait[m_own] = !ddr_busy;
    end else if (m_own >= 0 && ddr_valid) e_val[m_own] = 1'b1;
    chk("ddr_rd", ddr_rd, e_rd);
    chk("ddr_wr", ddr_wr, e_wr);
    chk("req_wait_n", req_wait_n, e_wait);
    chk("req_valid", req_valid, e_val);
    chk("owner", owner, m_last);
    if (cmd_ph) begin
      chk("ddr_addr", ddr_addr, req_addr[m_own*AW +: AW]);
      chk("ddr_burst", ddr_burst, req_burst[m_own*8 +: 8]);
      chk("ddr_din", ddr_din, req_din[m_own*64 +: 64]);
      chk("ddr_be", ddr_be, req_be[m_own*8 +: 8]);
    end else if (m_own < 0) chk("ddr_burst_idle", ddr_burst, 0);
    if (e_val != 0) chk("req_dout", req_dout, ddr_dout);
    if (ddr_rd && !ddr_busy) n_rdacc++;
    if (ddr_wr && !ddr_busy) begin
      n_wracc++;
      if (ddr_burst == 0) n_b0++;
    end
    if (ddr_wr && owner == 0 && !req_wait_n[0]) n_wait0++;
    for (int i = 0; i < N; i++) n_val[i] += int'(req_valid[i]);
    if (!rst_sys_n) begin
      m_own = -1; m_last = 0; m_next = 0; m_left = 0; m_started = 0;
    end else if (m_own < 0) begin
      w = -1;
      for (int k = N-1; k >= 0; k--) begin
`ifdef DDR_ARB_ROUND_ROBIN_EN
        c = (m_next + k) % N;
`else
        c = k;
`endif
        if (req_rd[c] || req_wr[c]) w = c;
      end
      if (w >= 0) begin
        m_own = w;
        m_rd = req_rd[w];
        m_left = req_burst[w*8 +: 8] == 0 ? 1 : int'(req_burst[w*8 +: 8]);
        m_started = 0;
        m_last = w;
        m_next = (w + 1) % N;
        grants.push_back(w);
      end
    end else if (m_rd && m_started) begin
      if (ddr_valid) begin
        m_left--;
        if (m_left == 0) m_own = -1;
      end
    end else if ((m_rd ? req_rd[m_own] : req_wr[m_own]) && !ddr_busy) begin
      if (m_rd) m_started = 1;
      else begin
        m_left--;
        if (m_left == 0) m_own = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clr();
    n_rdacc = 0; n_wracc = 0; n_wait0 = 0; n_b0 = 0;
    for (int i = 0; i < N; i++) n_val[i] = 0;
    grants.delete();
  endtask

  task automatic setreq(input int i, input bit rd, input bit wr, input int burst, input logic [AW-1:0] addr);
    req_rd[i] = rd;
    req_wr[i] = wr;
    req_burst[i*8 +: 8] = 8'(burst);
    req_addr[i*AW +: AW] = addr;
    req_din[i*64 +: 64] = {$urandom, $urandom};
    req_be[i*8 +: 8] = 8'($urandom);
  endtask

  // hold each strobe until its single command beat is accepted
  task automatic serve(input int max);
    int t = 0;
    logic [N-1:0] a;
    while ((req_rd | req_wr) != 0 && t < max) begin
      @(negedge clk_sys);
      a = req_wait_n & (req_rd | req_wr);
      @(posedge clk_sys);
      #1;
      req_rd &= ~a;
      req_wr &= ~a;
      t++;
    end
    chk("serve_timeout", 64'((req_rd | req_wr) == 0), 1);
  endtask

  task automatic beats(input int n);
    repeat (n) begin
      ddr_valid = 1'b1;
      ddr_dout = {$urandom, $urandom};
      tick();
      ddr_valid = 1'b0;
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) n_val[i] = 0;
    tick(); tick(); tick();
    chk("rst_wait_n", req_wait_n, 0);
    chk("rst_burst", ddr_burst, 0);
    rst_sys_n = 1'b1;
    tick();
    // requester 1 read burst 4
    clr();
    setreq(1, 1, 0, 4, 29'h100);
    serve(20);
    beats(4);
    repeat (3) tick();
    chk("t040_rd_cycles", n_rdacc, 1);
    chk("t040_val1", n_val[1], 4);
    chk("t040_val0", n_val[0], 0);
    chk("t040_val2", n_val[2], 0);
    chk("t040_grant", grants.size() > 0 ? grants[0] : -1, 1);
    // requester 0 write burst 2 behind three busy cycles
    clr();
    ddr_busy = 1'b1;
    setreq(0, 0, 1, 2, 29'h40);
    tick();
    repeat (3) tick();
    ddr_busy = 1'b0;
    tick();
    req_din[63:0] = {$urandom, $urandom};
    tick();
    req_wr[0] = 1'b0;
    repeat (3) tick();
    chk("t041_wait_lo", n_wait0, 3);
    chk("t041_beats", n_wracc, 2);
    // simultaneous requesters 0 and 2
    clr();
    setreq(0, 0, 1, 1, 29'h11);
    setreq(2, 0, 1, 1, 29'h22);
    serve(30);
    repeat (2) tick();
    chk("t042_ngrants", grants.size(), 2);
`ifdef DDR_ARB_ROUND_ROBIN_EN
    chk("t042_first", grants.size() > 0 ? grants[0] : -1, 2);
`else
    chk("t042_first", grants.size() > 0 ? grants[0] : -1, 0);
`endif
    // burst 0 write is a single beat
    clr();
    setreq(1, 0, 1, 0, 29'h7);
    serve(20);
    repeat (3) tick();
    chk("t043_beats", n_wracc, 1);
    chk("t043_burst0", n_b0, 1);
    // reset inside a read burst
    clr();
    setreq(2, 1, 0, 4, 29'h200);
    serve(20);
    beats(1);
    rst_sys_n = 1'b0;
    tick();
    rst_sys_n = 1'b1;
    beats(3);
    repeat (2) tick();
    chk("t044_val2", n_val[2], 1);
    chk("t044_owner", owner, 0);
    // stray ddr_valid while idle
    clr();
    beats(3);
    chk("t045_val", n_val[0] + n_val[1] + n_val[2], 0);
    chk("t045_grants", grants.size(), 0);
    // randomized traffic
    repeat (4000) begin
      rst_sys_n = ($urandom % 300) != 0;
      ddr_busy = ($urandom % 3) == 0;
      ddr_valid = ($urandom % 3) == 0;
      ddr_dout = {$urandom, $urandom};
      for (int i = 0; i < N; i++)
        if ($urandom % 5 == 0)
          setreq(i, ($urandom % 3) == 0, ($urandom % 3) == 0, int'($urandom % 6), AW'($urandom));
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ddr_arbiter.md
DDR_ARBITER -- requirements
Module: ddr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of requesters (2..4); index 0 is highest fixed priority.
REQ-002 Parameter ADDR_W, default 29: DDR word address width (64-bit words).
REQ-003 Port clk_sys  in  1: system clock; the block uses this single clock.
REQ-004 Port rst_sys_n  in  1: reset, synchronous, active-low.
REQ-005 Ports req_rd, req_wr  in  NUM_REQ: per-requester read/write strobes, held until accepted.
REQ-006 Ports req_addr  in  NUM_REQ*ADDR_W; req_burst  in  NUM_REQ*8; req_din  in  NUM_REQ*64; req_be  in  NUM_REQ*8: per-requester command fields.
REQ-007 Ports req_wait_n  out  NUM_REQ: beat accepted; req_valid  out  NUM_REQ: read beat for owner; req_dout  out  64: shared read data.
REQ-008 Ports ddr_rd, ddr_wr  out  1; ddr_addr  out  ADDR_W; ddr_burst  out  8; ddr_din  out  64; ddr_be  out  8: DDR command side.
REQ-009 Ports ddr_busy  in  1; ddr_dout  in  64; ddr_valid  in  1: DDR response side.
REQ-010 Port owner  out  2: current grant index, for debug/LED use.

Function
REQ-011 FSM states IDLE, CMD, RDATA, WDATA; owner is latched only in IDLE.
REQ-012 IDLE: any pending req_rd|req_wr -> latch winner, load beat count from its req_burst (0 treated as 1), go CMD next cycle; no DDR strobe is driven in IDLE.
REQ-013 CMD/WDATA: ddr_* equal owner's fields combinationally; owner's req_wait_n = ~ddr_busy; all other req_wait_n = 0.
REQ-014 CMD read accepted (ddr_rd & ~ddr_busy) -> RDATA; ddr_rd deasserts the cycle after acceptance.
REQ-015 RDATA: each ddr_valid pulses owner's req_valid same cycle, req_dout = ddr_dout; after the final beat -> IDLE.
REQ-016 CMD write accepted -> if burst = 1 -> IDLE, else WDATA; each further accepted beat decrements count; last beat -> IDLE.
REQ-017 Owner dropping its strobe mid-burst does not end the burst; the arbiter waits (ddr strobes follow owner, deasserted).
REQ-018 Simultaneous requests: winner per REQ-030; a requester asserting both rd and wr is serviced as a read.
REQ-019 ddr_valid in any state other than RDATA is ignored; req_valid stays 0.
REQ-020 Minimum gap: one IDLE cycle between consecutive grants.

Reset
REQ-021 With rst_sys_n low at a clock edge: state = IDLE, owner = 0, counters = 0, round-robin pointer = 0.
REQ-022 During and after reset until a grant: ddr_rd = ddr_wr = 0, req_wait_n = 0, req_valid = 0, ddr_burst = 0.
REQ-023 Reset mid-burst abandons the transaction; outstanding beats arriving afterwards are ignored per REQ-019.

Configuration
REQ-030 Macro DDR_ARB_ROUND_ROBIN_EN: defined -> round-robin; the search starts at the requester after the last owner. Undefined -> fixed priority, lowest index wins.

Structure
REQ-031 Shared package cave_ddr_pkg holds the FSM state enum, DDR_DATA_W=64, DDR_BE_W=8, DDR_BURST_W=8.
REQ-032 One sub-module, ddr_arb_pick: combinational grant picker (request vector + pointer -> one-hot winner and index).

Verification
REQ-040 Requester 1 reads, burst 4, addr 0x100, ddr_busy=0 -> ddr_rd for 1 cycle; 4 ddr_valid beats -> 4 req_valid[1] pulses; req_valid[0] and req_valid[2] stay 0; back to IDLE.
REQ-041 Requester 0 writes burst 2 with ddr_busy high for 3 cycles -> req_wait_n[0] = 0 for those 3 cycles; then 2 accepted beats; ddr_din tracks req_din[0].
REQ-042 Requesters 0 and 2 request in the same cycle, fixed mode -> 0 is served first, then 2. With DDR_ARB_ROUND_ROBIN_EN and last owner 0 -> 2 is served first.
REQ-043 req_burst=0 write -> exactly one beat is issued with ddr_burst=0 passed through; return to IDLE.
REQ-044 rst_sys_n pulsed low in RDATA after 1 of 4 beats -> IDLE with all outputs 0; later ddr_valid produces no req_valid.
REQ-045 Stray ddr_valid in IDLE -> no req_valid; state unchanged.
